iob_fifo_wr_arb: RTL and testbench
==================================

IOB_FIFO_WR_ARB -- requirements
Module: iob_fifo_wr_arb

Interface
REQ-001 SHALL have parameters:
- N_REQ, default 4, number of write requesters (2..16).
- DATA_W, default 32, word width; equals the FIFO write data width.
- ADDR_W, default 8, FIFO address width; FIFO capacity is 2^ADDR_W words.
- MAX_PKT_LEN, default 16, maximum words per packet (1..2^ADDR_W).

REQ-002 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous active-high reset.
- cke_i  in  1  clock enable; all state frozen when low.
- rst_i  in  1  synchronous clear, same effect as reset.
- req_valid_i  in  N_REQ  per-requester word valid.
- req_data_i  in  N_REQ*DATA_W  per-requester data; requester k occupies bits [k*DATA_W +: DATA_W].
- req_last_i  in  N_REQ  last word of packet.
- req_ready_o  out  N_REQ  per-requester accept.
- fifo_w_en_o  out  1  FIFO write enable.
- fifo_w_data_o  out  DATA_W  FIFO write data.
- fifo_w_full_i  in  1  FIFO full.
- fifo_level_i  in  ADDR_W+1  FIFO occupancy in words.
- grant_o  out  N_REQ  one-hot current owner; zero when idle.
- err_o  out  1  sticky packet-overlength flag.

REQ-003 Clock is clk_i; reset is arst_i, asynchronous, active-high.

Function
REQ-004 FSM SHALL have two states, IDLE and LOCK.
REQ-005 Admission SHALL require free space ((2^ADDR_W) - fifo_level_i) >= MAX_PKT_LEN, computed in ADDR_W+1 bits.
REQ-006 In IDLE, with at least one req_valid_i bit set and admission true, the block SHALL select winner g:
- g is the first valid index found searching upward, with wrap-around, from ptr+1.
- The block registers g into grant_o and enters LOCK on the next enabled edge.
REQ-007 In IDLE, req_ready_o SHALL be 0 and fifo_w_en_o SHALL be 0.
REQ-008 In LOCK:
- req_ready_o[g] = ~fifo_w_full_i; all other ready bits are 0.
- fifo_w_en_o = req_valid_i[g] & ~fifo_w_full_i, combinational.
- fifo_w_data_o = slice g of req_data_i, always driven from the registered grant.
REQ-009 A beat is a cycle in LOCK with fifo_w_en_o = 1. A beat counter SHALL:
- clear on entry to LOCK;
- increment per beat;
- have width clog2(MAX_PKT_LEN+1).
REQ-010 A beat with req_last_i[g] = 1 SHALL end the packet:
- next state IDLE, grant_o = 0, ptr = g.
REQ-011 A beat that is the MAX_PKT_LEN-th beat with req_last_i[g] = 0 SHALL end the packet the same way and set err_o.
- err_o stays set until reset or rst_i.
REQ-012 While fifo_w_full_i is high in LOCK, the block SHALL stall:
- no beat occurs;
- grant and beat counter are held.
REQ-013 A requester dropping req_valid_i mid-packet SHALL NOT release the grant; the block waits.
REQ-014 Minimum spacing: the last beat of a packet is followed by one IDLE cycle, then the next grant.
- Maximum throughput is therefore MAX_PKT_LEN words per MAX_PKT_LEN+1 cycles.
REQ-015 With cke_i low, the block SHALL freeze all registers.
- Outputs continue to be driven combinationally from the frozen state.
- fifo_w_en_o is additionally gated by cke_i.

Reset
REQ-016 Reset and rst_i SHALL set:
- state IDLE, grant_o 0, ptr N_REQ-1 (so requester 0 wins first), beat counter 0, err_o 0;
- req_ready_o 0 and fifo_w_en_o 0.
REQ-017 Reset mid-packet SHALL abort the packet.
- No further beats are issued for it.
- FIFO contents are not this block's concern.

Verification
REQ-018 The bench SHALL cover:
- Reset, all valids high, level 0 -> grant_o = 0001 one cycle after reset release. Requester 0 sends 3 words with last on word 3. Then grant_o = 0010 after one IDLE cycle.
- Requesters 1 and 3 continuously valid, 1-word packets -> grants alternate 0010, 1000, 0010; no requester is starved.
- level = 2^ADDR_W - MAX_PKT_LEN + 1 with valid pending -> no grant. Level drops by 1 -> grant on the next edge.
- fifo_w_full_i pulsed high for 2 cycles mid-packet -> fifo_w_en_o = 0 and ready = 0 for those cycles. Data order and beat count are preserved.
- MAX_PKT_LEN = 4, requester sends 6 words without last -> exactly 4 beats, then IDLE. err_o = 1 from the next cycle and stays set until rst_i.
- arst_i asserted during the beat 2 cycle -> grant_o, req_ready_o and fifo_w_en_o go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iob_fifo_wr_arb.sv
// Round-robin packet arbiter: grants one requester at a time exclusive write
// access to a FIFO, admitting a packet only when a maximum-length packet fits.
module iob_fifo_wr_arb #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      cke_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    input  logic [N_REQ-1:0]          req_last_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      fifo_w_en_o,
    output logic [DATA_W-1:0]         fifo_w_data_o,
    input  logic                      fifo_w_full_i,
    input  logic [ADDR_W:0]           fifo_level_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      err_o
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam int unsigned LVL_W = ADDR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q,  gidx_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;

    logic [LVL_W-1:0]   free_c;
    logic               admit_c;
    logic               win_found_c;
    logic [PTR_W-1:0]   win_idx_c;
    logic               lock_c;
    logic               sel_valid_c;
    logic               sel_last_c;
    logic               beat_c;

    // Free space and admission against a worst-case packet
    assign free_c  = LVL_W'(2 ** ADDR_W) - fifo_level_i;
    assign admit_c = (free_c >= LVL_W'(MAX_PKT_LEN));

    // Round-robin search: first valid index upward from ptr+1, wrapping
    always_comb begin
        int unsigned j;
        j           = 0;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            j = (32'(ptr_q) + i) % N_REQ;
            if (!win_found_c && req_valid_i[PTR_W'(j)]) begin
                win_found_c = 1'b1;
                win_idx_c   = PTR_W'(j);
            end
        end
    end

    assign lock_c      = (state_q == LOCK);
    assign sel_valid_c = req_valid_i[gidx_q];
    assign sel_last_c  = req_last_i[gidx_q];
    assign beat_c      = lock_c & sel_valid_c & ~fifo_w_full_i & cke_i & ~rst_i;

    assign req_ready_o   = (lock_c && !fifo_w_full_i && !rst_i) ? grant_q : '0;
    assign fifo_w_en_o   = beat_c;
    assign fifo_w_data_o = req_data_i[32'(gidx_q)*DATA_W +: DATA_W];
    assign grant_o       = grant_q;
    assign err_o         = err_q;

    // Next-state: grant on admission in IDLE, count beats and release in LOCK
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (admit_c && win_found_c) begin
                    state_d = LOCK;
                    gidx_d  = win_idx_c;
                    grant_d = N_REQ'(1) << win_idx_c;
                    cnt_d   = '0;
                end
            end
            LOCK: begin
                if (beat_c) begin
                    if (sel_last_c || (cnt_q == CNT_W'(MAX_PKT_LEN - 1))) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = gidx_q;
                        cnt_d   = '0;
                        if (!sel_last_c) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers: async reset, clock enable, synchronous clear
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                grant_q <= '0;
                gidx_q  <= '0;
                ptr_q   <= PTR_W'(N_REQ - 1);
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                grant_q <= grant_d;
                gidx_q  <= gidx_d;
                ptr_q   <= ptr_d;
                cnt_q   <= cnt_d;
                err_q   <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_iob_fifo_wr_arb.sv
// Bench for iob_fifo_wr_arb: directed scenarios plus random traffic against
// a packet-level reference model of the arbiter.
module tb_iob_fifo_wr_arb;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int MAXL  = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              arst_i, cke_i, rst_i;
    logic [N-1:0]      req_valid, req_last, req_ready, grant;
    logic [N*DW-1:0]   req_data;
    logic              wen, full, err;
    logic [DW-1:0]     wdata;
    logic [AW:0]       level;

    iob_fifo_wr_arb #(
        .N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_PKT_LEN(MAXL)
    ) dut (
        .clk_i(clk), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .fifo_w_en_o(wen), .fifo_w_data_o(wdata),
        .fifo_w_full_i(full), .fifo_level_i(level),
        .grant_o(grant), .err_o(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 when idle), last winner, beats, error
    int m_owner, m_ptr, m_beats;
    bit m_err;

    logic [DW-1:0] wq[$];
    logic          seen_wen;
    logic [N-1:0]  seen_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] slice(input int k);
        return req_data[k*DW +: DW];
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_beats = 0;
        m_err   = 1'b0;
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = DW'($urandom);
    endtask

    // One clock: check outputs at negedge against the model, then advance it
    task automatic run_cycle();
        logic [N-1:0] eg, er;
        logic         ew;
        int           free;
        @(negedge clk);
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        er = (m_owner >= 0 && !full && !rst_i) ? eg : '0;
        ew = (m_owner >= 0) && req_valid[m_owner] && !full && cke_i && !rst_i;
        check("grant", grant, eg);
        check("ready", req_ready, er);
        check("wen", wen, ew);
        check("err", err, m_err);
        if (ew) check("wdata", wdata, slice(m_owner));
        seen_wen   = wen;
        seen_ready = req_ready;
        if (wen) wq.push_back(wdata);
        if (cke_i) begin
            if (rst_i) begin
                m_reset();
            end else if (m_owner < 0) begin
                free = DEPTH - int'(level);
                if (req_valid != '0 && free >= MAXL) begin
                    for (int i = 1; i <= N; i++) begin
                        if (m_owner < 0 && req_valid[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
                    end
                    m_beats = 0;
                end
            end else if (ew) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == MAXL) begin
                    if (!req_last[m_owner]) m_err = 1'b1;
                    m_ptr   = m_owner;
                    m_owner = -1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        arst_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_wen", wen, 0);
        check("rst_err", err, 0);
        arst_i = 1'b0;
        m_reset();
    endtask

    task automatic sync_reset();
        cke_i = 1'b1;
        rst_i = 1'b1;
        run_cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        arst_i = 1'b0; cke_i = 1'b1; rst_i = 1'b0;
        req_valid = '0; req_last = '0; full = 1'b0; level = '0;
        rand_data();
        m_reset();
        hard_reset();

        // Requester 0 wins first, 3-word packet, then requester 1
        req_valid = '1;
        wq.delete();
        run_cycle();
        check("s1_grant0", grant, 4'b0001);
        rand_data(); run_cycle();
        rand_data(); run_cycle();
        req_last = 4'b0001; rand_data(); run_cycle();
        req_last = '0;
        check("s1_idle", grant, 0);
        check("s1_beats", wq.size(), 3);
        run_cycle();
        check("s1_grant1", grant, 4'b0010);

        // Requesters 1 and 3 alternate with 1-word packets
        req_valid = 4'b1010; req_last = 4'b1010;
        sync_reset();
        run_cycle(); check("s2_g1", grant, 4'b0010);
        run_cycle(); run_cycle(); check("s2_g3", grant, 4'b1000);
        run_cycle(); run_cycle(); check("s2_g1b", grant, 4'b0010);

        // Admission threshold
        req_valid = '0; req_last = '0;
        sync_reset();
        req_valid = 4'b0001;
        level = 5'(DEPTH - MAXL + 1);
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            check("s3_nogrant", grant, 0);
        end
        level = 5'(DEPTH - MAXL);
        run_cycle();
        check("s3_grant", grant, 4'b0001);
        req_last = 4'b0001; run_cycle(); req_last = '0;
        level = '0;

        // Full stall for 2 cycles mid-packet
        req_valid = '0;
        sync_reset();
        req_valid = 4'b0001;
        wq.delete();
        run_cycle();
        for (int k = 0; k < 12 && grant != 0; k++) begin
            full = (k == 1 || k == 2);
            req_data[DW-1:0] = DW'(16'hA0 + wq.size());
            req_last = (wq.size() == 3) ? 4'b0001 : 4'b0000;
            run_cycle();
            if (k == 1 || k == 2) begin
                check("s4_full_wen", seen_wen, 0);
                check("s4_full_ready", seen_ready, 0);
            end
        end
        full = 1'b0; req_last = '0;
        check("s4_done", grant, 0);
        check("s4_beats", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) check("s4_order", wq[i], 64'(16'hA0 + i));

        // Overlength packet: 6 words without last
        req_valid = '0;
        sync_reset();
        req_valid = 4'b0100;
        wq.delete();
        run_cycle();
        check("s5_grant", grant, 4'b0100);
        for (int k = 0; k < 12 && grant != 0; k++) begin
            rand_data(); run_cycle();
        end
        check("s5_release", grant, 0);
        check("s5_beats", wq.size(), MAXL);
        check("s5_err", err, 1);
        for (int k = 0; k < 10; k++) begin
            req_valid = (wq.size() < 6) ? 4'b0100 : 4'b0000;
            rand_data(); run_cycle();
        end
        check("s5_total", wq.size(), 6);
        check("s5_sticky", err, 1);
        sync_reset();
        check("s5_clear_err", err, 0);
        check("s5_clear_grant", grant, 0);

        // Async reset during the second beat
        req_valid = '0;
        sync_reset();
        req_valid = 4'b0001;
        run_cycle();
        run_cycle();
        #1;
        check("s6_pre_wen", wen, 1);
        arst_i = 1'b1;
        #1;
        check("s6_grant", grant, 0);
        check("s6_ready", req_ready, 0);
        check("s6_wen", wen, 0);
        m_reset();
        @(posedge clk);
        #1;
        arst_i = 1'b0;
        for (int k = 0; k < 3; k++) run_cycle();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom);
            req_last  = N'($urandom) & N'($urandom);
            rand_data();
            full  = ($urandom % 5 == 0);
            level = ($urandom % 4 == 0) ? 5'($urandom_range(0, DEPTH)) : 5'($urandom_range(0, 4));
            cke_i = ($urandom % 8 != 0);
            rst_i = ($urandom % 150 == 0);
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
